// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RS  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    StRun,
    StLoadStall,
    StFlush,
    StMemWait
  } hz_state_t;

  localparam logic [7:0] MEM_TIMEOUT = 8'd255;
  localparam int unsigned CntW = 16;

endpackage

// File: rtl/hazard_if.sv
// Pipeline-facing signal bundle of the hazard controller.
interface hazard_if;
  import hazard_pkg::*;

  logic [4:0]          id_rs1_addr_i;
  logic [4:0]          id_rs2_addr_i;
  logic                id_rs1_used_i;
  logic                id_rs2_used_i;
  logic [4:0]          ex_rd_addr_i;
  logic                ex_rd_wr_en_i;
  logic                ex_is_load_i;
  logic [4:0]          mem_rd_addr_i;
  logic                mem_rd_wr_en_i;
  logic                branch_taken_i;
  logic                mem_req_i;
  logic                mem_ack_i;
  fwd_sel_t            forward_reg1_o;
  fwd_sel_t            forward_reg2_o;
  logic                stall_o;
  logic                flush_o;
  logic                freeze_o;
  logic                timeout_o;
  logic [CntW-1:0]     stall_cnt_o;
  logic [CntW-1:0]     flush_cnt_o;

  modport master (
    output id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
    output ex_rd_addr_i, ex_rd_wr_en_i, ex_is_load_i,
    output mem_rd_addr_i, mem_rd_wr_en_i,
    output branch_taken_i, mem_req_i, mem_ack_i,
    input  forward_reg1_o, forward_reg2_o, stall_o, flush_o, freeze_o,
    input  timeout_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
    input  ex_rd_addr_i, ex_rd_wr_en_i, ex_is_load_i,
    input  mem_rd_addr_i, mem_rd_wr_en_i,
    input  branch_taken_i, mem_req_i, mem_ack_i,
    output forward_reg1_o, forward_reg2_o, stall_o, flush_o, freeze_o,
    output timeout_o, stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/forward_select.sv
// Per-operand forwarding comparator: EX beats MEM, x0 never forwards.
module forward_select
  import hazard_pkg::*;
(
  input  logic [4:0] rs_addr_i,
  input  logic [4:0] ex_rd_addr_i,
  input  logic       ex_rd_wr_en_i,
  input  logic       ex_is_load_i,
  input  logic [4:0] mem_rd_addr_i,
  input  logic       mem_rd_wr_en_i,
  output fwd_sel_t   sel_o,
  output logic       load_hit_o
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = ex_rd_wr_en_i && (ex_rd_addr_i != 5'd0) && (ex_rd_addr_i == rs_addr_i);
  assign mem_hit = mem_rd_wr_en_i && (mem_rd_addr_i != 5'd0) && (mem_rd_addr_i == rs_addr_i);

  // A load in EX has no data yet; the caller decides whether the operand is really used.
  assign load_hit_o = ex_hit && ex_is_load_i;

  always_comb begin
    sel_o = FWD_RS;
    if (ex_hit && !ex_is_load_i) begin
      sel_o = FWD_EX;
    end else if (mem_hit) begin
      sel_o = FWD_MEM;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush and memory-wait freeze.
module hazard_controller
  import hazard_pkg::*;
(
  input logic     clk_i,
  input logic     rst_i,
  hazard_if.slave hz
);

  fwd_sel_t sel1, sel2;
  logic     hit1, hit2;
  logic     load_use;

  forward_select u_fwd_rs1 (
    .rs_addr_i      (hz.id_rs1_addr_i),
    .ex_rd_addr_i   (hz.ex_rd_addr_i),
    .ex_rd_wr_en_i  (hz.ex_rd_wr_en_i),
    .ex_is_load_i   (hz.ex_is_load_i),
    .mem_rd_addr_i  (hz.mem_rd_addr_i),
    .mem_rd_wr_en_i (hz.mem_rd_wr_en_i),
    .sel_o          (sel1),
    .load_hit_o     (hit1)
  );

  forward_select u_fwd_rs2 (
    .rs_addr_i      (hz.id_rs2_addr_i),
    .ex_rd_addr_i   (hz.ex_rd_addr_i),
    .ex_rd_wr_en_i  (hz.ex_rd_wr_en_i),
    .ex_is_load_i   (hz.ex_is_load_i),
    .mem_rd_addr_i  (hz.mem_rd_addr_i),
    .mem_rd_wr_en_i (hz.mem_rd_wr_en_i),
    .sel_o          (sel2),
    .load_hit_o     (hit2)
  );

  assign load_use = (hit1 && hz.id_rs1_used_i) || (hit2 && hz.id_rs2_used_i);

  hz_state_t       state_q, state_d;
  logic [7:0]      wait_cnt_q, wait_cnt_d;
  logic            timeout_q, timeout_d;
  logic [CntW-1:0] stall_cnt_q, stall_cnt_d;
  logic [CntW-1:0] flush_cnt_q, flush_cnt_d;
  logic            stall, flush, freeze;

  always_comb begin
    state_d    = StRun;
    stall      = 1'b0;
    flush      = 1'b0;
    freeze     = 1'b0;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;

    // Once waiting, only the ack releases the freeze; a fresh request freezes unless acked.
    if (state_q == StMemWait) begin
      freeze = !hz.mem_ack_i;
    end else begin
      freeze = hz.mem_req_i && !hz.mem_ack_i;
    end

    if (freeze) begin
      state_d = StMemWait;
      if (state_q != StMemWait) begin
        wait_cnt_d = 8'd0;
      end else begin
        if (wait_cnt_q != MEM_TIMEOUT) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
        if (wait_cnt_d == MEM_TIMEOUT) begin
          timeout_d = 1'b1;
        end
      end
    end else begin
      // The MEM_WAIT ack cycle behaves like RUN so pending branches/hazards are not lost.
      case (state_q)
        StRun, StMemWait: begin
          if (hz.branch_taken_i) begin
            flush   = 1'b1;
            state_d = StFlush;
          end else if (load_use) begin
            stall   = 1'b1;
            state_d = StLoadStall;
          end
        end
        StLoadStall: begin
          if (hz.branch_taken_i) begin
            flush   = 1'b1;
            state_d = StFlush;
          end
        end
        default: state_d = StRun;
      endcase
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    flush_cnt_d = flush_cnt_q;
    if (flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= StRun;
      wait_cnt_q  <= 8'd0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Combinational outputs are forced quiet while reset is held.
  assign hz.forward_reg1_o = rst_i ? sel1 : FWD_RS;
  assign hz.forward_reg2_o = rst_i ? sel2 : FWD_RS;
  assign hz.stall_o        = rst_i && stall;
  assign hz.flush_o        = rst_i && flush;
  assign hz.freeze_o       = rst_i && freeze;
  assign hz.timeout_o      = timeout_q;
  assign hz.stall_cnt_o    = stall_cnt_q;
  assign hz.flush_cnt_o    = flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios plus a randomized model run.
module tb_hazard_controller;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic rst_i;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  hazard_if hif ();

  hazard_controller dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .hz    (hif)
  );

  task automatic set_idle();
    hif.id_rs1_addr_i  = 5'd0;
    hif.id_rs2_addr_i  = 5'd0;
    hif.id_rs1_used_i  = 1'b0;
    hif.id_rs2_used_i  = 1'b0;
    hif.ex_rd_addr_i   = 5'd0;
    hif.ex_rd_wr_en_i  = 1'b0;
    hif.ex_is_load_i   = 1'b0;
    hif.mem_rd_addr_i  = 5'd0;
    hif.mem_rd_wr_en_i = 1'b0;
    hif.branch_taken_i = 1'b0;
    hif.mem_req_i      = 1'b0;
    hif.mem_ack_i      = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    set_idle();
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b1;
  endtask

  // Load in EX writing rd 7, decode reads it through rs2.
  task automatic set_load_use();
    hif.ex_rd_addr_i  = 5'd7;
    hif.ex_rd_wr_en_i = 1'b1;
    hif.ex_is_load_i  = 1'b1;
    hif.id_rs2_addr_i = 5'd7;
    hif.id_rs2_used_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    set_load_use();
    hif.id_rs1_addr_i  = 5'd9;
    hif.mem_rd_addr_i  = 5'd9;
    hif.mem_rd_wr_en_i = 1'b1;
    hif.branch_taken_i = 1'b1;
    hif.mem_req_i      = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (hif.forward_reg1_o !== FWD_RS) $display("FAIL rst_fwd1 got=%0d exp=0", hif.forward_reg1_o); else n_pass++;
    n_checks++; if (hif.forward_reg2_o !== FWD_RS) $display("FAIL rst_fwd2 got=%0d exp=0", hif.forward_reg2_o); else n_pass++;
    n_checks++; if ({hif.stall_o, hif.flush_o, hif.freeze_o, hif.timeout_o} !== 4'b0)
      $display("FAIL rst_ctl got=%b exp=0000", {hif.stall_o, hif.flush_o, hif.freeze_o, hif.timeout_o}); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if ({hif.stall_cnt_o, hif.flush_cnt_o} !== 32'd0)
      $display("FAIL rst_cnt got=%h exp=0", {hif.stall_cnt_o, hif.flush_cnt_o}); else n_pass++;
  endtask

  task automatic test_forwarding();
    do_reset();
    hif.ex_rd_addr_i   = 5'd5;
    hif.ex_rd_wr_en_i  = 1'b1;
    hif.mem_rd_addr_i  = 5'd5;
    hif.mem_rd_wr_en_i = 1'b1;
    hif.id_rs1_addr_i  = 5'd5;
    hif.id_rs1_used_i  = 1'b1;
    #1;
    n_checks++; if (hif.forward_reg1_o !== FWD_EX) $display("FAIL fwd_ex_prio got=%0d exp=1", hif.forward_reg1_o); else n_pass++;
    hif.ex_rd_wr_en_i = 1'b0;
    #1;
    n_checks++; if (hif.forward_reg1_o !== FWD_MEM) $display("FAIL fwd_mem got=%0d exp=2", hif.forward_reg1_o); else n_pass++;
    hif.id_rs1_addr_i = 5'd0;
    hif.ex_rd_addr_i  = 5'd0;
    hif.ex_rd_wr_en_i = 1'b1;
    hif.mem_rd_addr_i = 5'd0;
    #1;
    n_checks++; if (hif.forward_reg1_o !== FWD_RS) $display("FAIL fwd_x0 got=%0d exp=0", hif.forward_reg1_o); else n_pass++;
    hif.ex_is_load_i = 1'b1;
    #1;
    n_checks++; if (hif.stall_o !== 1'b0) $display("FAIL x0_stall got=%b exp=0", hif.stall_o); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use();
    hif.id_rs1_addr_i = 5'd3;
    hif.id_rs1_used_i = 1'b1;
    #1;
    n_checks++; if (hif.stall_o !== 1'b1) $display("FAIL lu_stall got=%b exp=1", hif.stall_o); else n_pass++;
    @(posedge clk); #1;
    // Load has moved to MEM; EX still shows a matching load to prove the bubble never re-stalls.
    hif.mem_rd_addr_i  = 5'd7;
    hif.mem_rd_wr_en_i = 1'b1;
    #1;
    n_checks++; if (hif.stall_o !== 1'b0) $display("FAIL lu_bubble_stall got=%b exp=0", hif.stall_o); else n_pass++;
    n_checks++; if (hif.forward_reg2_o !== FWD_MEM) $display("FAIL lu_fwd2 got=%0d exp=2", hif.forward_reg2_o); else n_pass++;
    n_checks++; if (hif.stall_cnt_o !== 16'd1) $display("FAIL lu_cnt got=%0d exp=1", hif.stall_cnt_o); else n_pass++;
    @(posedge clk); #1;
    set_idle();
    @(posedge clk); #1;
    n_checks++; if (hif.stall_cnt_o !== 16'd1) $display("FAIL lu_cnt_hold got=%0d exp=1", hif.stall_cnt_o); else n_pass++;
  endtask

  task automatic test_branch();
    do_reset();
    set_load_use();
    hif.branch_taken_i = 1'b1;
    #1;
    n_checks++; if ({hif.flush_o, hif.stall_o} !== 2'b10) $display("FAIL br_prio got=%b exp=10", {hif.flush_o, hif.stall_o}); else n_pass++;
    @(posedge clk); #1;
    hif.branch_taken_i = 1'b0;
    #1;
    n_checks++; if ({hif.flush_o, hif.stall_o} !== 2'b00) $display("FAIL br_flushst got=%b exp=00", {hif.flush_o, hif.stall_o}); else n_pass++;
    n_checks++; if (hif.flush_cnt_o !== 16'd1) $display("FAIL br_fcnt got=%0d exp=1", hif.flush_cnt_o); else n_pass++;
    n_checks++; if (hif.stall_cnt_o !== 16'd0) $display("FAIL br_scnt got=%0d exp=0", hif.stall_cnt_o); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (hif.stall_o !== 1'b1) $display("FAIL br_back_run got=%b exp=1", hif.stall_o); else n_pass++;
    // Reset while in the flush shadow must drop it: a hazard right after release stalls.
    do_reset();
    hif.branch_taken_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    hif.branch_taken_i = 1'b0;
    set_load_use();
    #1;
    n_checks++; if (hif.stall_o !== 1'b0) $display("FAIL br_rst_stall got=%b exp=0", hif.stall_o); else n_pass++;
    @(posedge clk); #1;
    rst_i = 1'b1;
    #1;
    n_checks++; if (hif.stall_o !== 1'b1) $display("FAIL br_rst_abort got=%b exp=1", hif.stall_o); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_mem_wait();
    do_reset();
    hif.mem_req_i      = 1'b1;
    hif.branch_taken_i = 1'b1;
    set_load_use();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if ({hif.freeze_o, hif.flush_o, hif.stall_o} !== 3'b100)
        $display("FAIL mw_freeze cyc=%0d got=%b exp=100", i, {hif.freeze_o, hif.flush_o, hif.stall_o}); else n_pass++;
      @(posedge clk); #1;
    end
    hif.mem_ack_i = 1'b1;
    #1;
    n_checks++; if ({hif.freeze_o, hif.flush_o, hif.stall_o} !== 3'b010)
      $display("FAIL mw_ack got=%b exp=010", {hif.freeze_o, hif.flush_o, hif.stall_o}); else n_pass++;
    @(posedge clk); #1;
    set_idle();
    #1;
    n_checks++; if ({hif.freeze_o, hif.flush_o} !== 2'b00) $display("FAIL mw_after got=%b exp=00", {hif.freeze_o, hif.flush_o}); else n_pass++;
    n_checks++; if (hif.flush_cnt_o !== 16'd1) $display("FAIL mw_fcnt got=%0d exp=1", hif.flush_cnt_o); else n_pass++;
    @(posedge clk); #1;
    hif.mem_req_i = 1'b1;
    hif.mem_ack_i = 1'b1;
    #1;
    n_checks++; if (hif.freeze_o !== 1'b0) $display("FAIL mw_same_ack got=%b exp=0", hif.freeze_o); else n_pass++;
    @(posedge clk); #1;
    set_idle();
    #1;
    n_checks++; if (hif.freeze_o !== 1'b0) $display("FAIL mw_same_ack_next got=%b exp=0", hif.freeze_o); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    do_reset();
    hif.mem_req_i = 1'b1;
    repeat (250) @(posedge clk);
    #1;
    n_checks++; if ({hif.freeze_o, hif.timeout_o} !== 2'b10) $display("FAIL to_early got=%b exp=10", {hif.freeze_o, hif.timeout_o}); else n_pass++;
    repeat (10) @(posedge clk);
    #1;
    n_checks++; if ({hif.freeze_o, hif.timeout_o} !== 2'b11) $display("FAIL to_set got=%b exp=11", {hif.freeze_o, hif.timeout_o}); else n_pass++;
    hif.mem_ack_i = 1'b1;
    #1;
    n_checks++; if (hif.freeze_o !== 1'b0) $display("FAIL to_ack got=%b exp=0", hif.freeze_o); else n_pass++;
    @(posedge clk); #1;
    set_idle();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (hif.timeout_o !== 1'b1) $display("FAIL to_sticky got=%b exp=1", hif.timeout_o); else n_pass++;
    // Reset in the middle of a wait clears everything and leaves no wait behind.
    hif.mem_req_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    #1;
    n_checks++; if ({hif.freeze_o, hif.timeout_o} !== 2'b00) $display("FAIL to_rst got=%b exp=00", {hif.freeze_o, hif.timeout_o}); else n_pass++;
    hif.mem_req_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b1;
    #1;
    n_checks++; if (hif.freeze_o !== 1'b0) $display("FAIL to_rst_abort got=%b exp=0", hif.freeze_o); else n_pass++;
    @(posedge clk); #1;
  endtask

  function automatic fwd_sel_t ref_fwd(input logic [4:0] rs);
    if (hif.ex_rd_wr_en_i && hif.ex_rd_addr_i != 5'd0 && hif.ex_rd_addr_i == rs && !hif.ex_is_load_i)
      return FWD_EX;
    if (hif.mem_rd_wr_en_i && hif.mem_rd_addr_i != 5'd0 && hif.mem_rd_addr_i == rs)
      return FWD_MEM;
    return FWD_RS;
  endfunction

  task automatic test_random();
    bit waiting = 0, bubble = 0, flushed = 0, tmo = 0;
    bit hazard, e_freeze, e_flush, e_stall;
    int waited = 0, s_cnt = 0, f_cnt = 0;
    fwd_sel_t e_f1, e_f2;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      hif.id_rs1_addr_i  = 5'($urandom_range(0, 3));
      hif.id_rs2_addr_i  = 5'($urandom_range(0, 3));
      hif.id_rs1_used_i  = 1'($urandom_range(0, 1));
      hif.id_rs2_used_i  = 1'($urandom_range(0, 1));
      hif.ex_rd_addr_i   = 5'($urandom_range(0, 3));
      hif.ex_rd_wr_en_i  = 1'($urandom_range(0, 1));
      hif.ex_is_load_i   = ($urandom_range(0, 2) == 0);
      hif.mem_rd_addr_i  = 5'($urandom_range(0, 3));
      hif.mem_rd_wr_en_i = 1'($urandom_range(0, 1));
      hif.branch_taken_i = ($urandom_range(0, 5) == 0);
      hif.mem_req_i      = ($urandom_range(0, 7) == 0);
      hif.mem_ack_i      = ($urandom_range(0, 2) == 0);
      #1;
      e_f1 = ref_fwd(hif.id_rs1_addr_i);
      e_f2 = ref_fwd(hif.id_rs2_addr_i);
      hazard = hif.ex_is_load_i && hif.ex_rd_wr_en_i && hif.ex_rd_addr_i != 5'd0 &&
               ((hif.id_rs1_used_i && hif.ex_rd_addr_i == hif.id_rs1_addr_i) ||
                (hif.id_rs2_used_i && hif.ex_rd_addr_i == hif.id_rs2_addr_i));
      e_freeze = waiting ? !hif.mem_ack_i : (hif.mem_req_i && !hif.mem_ack_i);
      e_flush  = !e_freeze && !flushed && hif.branch_taken_i;
      e_stall  = !e_freeze && !flushed && !bubble && !hif.branch_taken_i && hazard;
      n_checks++; if (hif.forward_reg1_o !== e_f1) $display("FAIL rnd_fwd1 c=%0d got=%0d exp=%0d", c, hif.forward_reg1_o, e_f1); else n_pass++;
      n_checks++; if (hif.forward_reg2_o !== e_f2) $display("FAIL rnd_fwd2 c=%0d got=%0d exp=%0d", c, hif.forward_reg2_o, e_f2); else n_pass++;
      n_checks++; if ({hif.freeze_o, hif.flush_o, hif.stall_o} !== {e_freeze, e_flush, e_stall})
        $display("FAIL rnd_ctl c=%0d got=%b exp=%b", c, {hif.freeze_o, hif.flush_o, hif.stall_o}, {e_freeze, e_flush, e_stall}); else n_pass++;
      n_checks++; if (hif.stall_cnt_o !== 16'(s_cnt) || hif.flush_cnt_o !== 16'(f_cnt) || hif.timeout_o !== tmo)
        $display("FAIL rnd_cnt c=%0d got=%0d/%0d/%b exp=%0d/%0d/%b", c, hif.stall_cnt_o, hif.flush_cnt_o,
                 hif.timeout_o, s_cnt, f_cnt, tmo); else n_pass++;
      if (e_freeze) begin
        waited = waiting ? waited + 1 : 0;
        if (waited >= 255) tmo = 1;
      end
      if (e_stall && s_cnt < 65535) s_cnt++;
      if (e_flush && f_cnt < 65535) f_cnt++;
      waiting = e_freeze;
      bubble  = e_stall;
      flushed = e_flush;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_i = 1'b0;
    set_idle();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, with ports named as below.
REQ-002 Ports, clock and reset first (name, direction, width, meaning):
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous reset, active-low.
- id_rs1_addr_i  in  5  rs1 of the instruction in decode.
- id_rs2_addr_i  in  5  rs2 of the instruction in decode.
- id_rs1_used_i  in  1  decode instruction reads rs1.
- id_rs2_used_i  in  1  decode instruction reads rs2.
- ex_rd_addr_i  in  5  EX destination register.
- ex_rd_wr_en_i  in  1  EX writes rd.
- ex_is_load_i  in  1  EX instruction is a load.
- mem_rd_addr_i  in  5  MEM destination register.
- mem_rd_wr_en_i  in  1  MEM writes rd.
- branch_taken_i  in  1  registered redirect from decode.
- mem_req_i  in  1  MEM stage data access pending.
- mem_ack_i  in  1  data memory completes the access.
- forward_reg1_o  out  2  operand-1 source select.
- forward_reg2_o  out  2  operand-2 source select.
- stall_o  out  1  decode inserts a bubble; fetch and PC hold.
- flush_o  out  1  decode replaces its instruction with NOP.
- freeze_o  out  1  all pipeline registers hold.
- timeout_o  out  1  sticky memory-wait watchdog error.
- stall_cnt_o  out  16  saturating count of stall cycles.
- flush_cnt_o  out  16  saturating count of flush cycles.

Function
REQ-003 Forwarding is combinational per operand:
- EX select: ex_rd_wr_en_i=1, ex_rd_addr_i!=0, ex_rd_addr_i==rsN, and ex_is_load_i=0.
- Else MEM select: mem_rd_wr_en_i=1, mem_rd_addr_i!=0, mem_rd_addr_i==rsN.
- Else RS select.
REQ-004 EX match SHALL take priority over MEM match, and register x0 SHALL never be forwarded.
REQ-005 Load-use hazard is defined as: ex_is_load_i=1, ex_rd_wr_en_i=1, ex_rd_addr_i!=0, and the EX rd matches a used rs1 or rs2.
REQ-006 A load-use hazard in state RUN SHALL assert stall_o combinationally for exactly that cycle, then move the FSM to LOAD_STALL.
REQ-007 LOAD_STALL lasts 1 cycle with stall_o=0, during which the operand selects MEM via REQ-003; the FSM then returns to RUN.
REQ-008 FSM states are RUN, LOAD_STALL, FLUSH and MEM_WAIT.
REQ-009 branch_taken_i=1 in RUN or LOAD_STALL SHALL assert flush_o combinationally, deassert stall_o that cycle, and enter FLUSH for 1 cycle with flush_o=0.
REQ-010 mem_req_i=1 with mem_ack_i=0 in any state SHALL assert freeze_o combinationally and enter MEM_WAIT.
REQ-011 In MEM_WAIT, freeze_o=1 until mem_ack_i=1; the ack cycle has freeze_o=0, and the next state is RUN.
REQ-012 Event priority SHALL be freeze > flush > stall.
- While freeze_o=1: stall_o=0, flush_o=0.
- A branch or hazard present on the ack cycle SHALL be serviced in that cycle.
REQ-013 mem_req_i with mem_ack_i=1 in the same cycle SHALL complete with no freeze.
REQ-014 An 8-bit wait counter clears on MEM_WAIT entry and increments each MEM_WAIT cycle.
REQ-015 Reaching 255 SHALL set timeout_o, which stays set until reset; the FSM keeps waiting.
REQ-016 stall_cnt_o SHALL increment each cycle stall_o=1, and flush_cnt_o each cycle flush_o=1; both saturate at 16'hFFFF.

Reset
REQ-017 While rst_i=0:
- state=RUN.
- forward_reg1_o=forward_reg2_o=FWD_RS.
- stall_o, flush_o, freeze_o, timeout_o = 0.
- Both counters and the wait counter = 0.
REQ-018 Reset asserted mid-MEM_WAIT or mid-FLUSH SHALL abort immediately, with no event carried past reset.

Structure
REQ-019 Package hazard_pkg SHALL hold:
- fwd_sel_t: FWD_RS=2'b00, FWD_EX=2'b01, FWD_MEM=2'b10.
- hz_state_t.
- MEM_TIMEOUT=255.
REQ-020 Sub-module forward_select (comparator plus priority per operand) SHALL be instantiated twice; the FSM and counters stay in the top.

Verification
REQ-021 Forwarding:
- EX rd=5 ALU, MEM rd=5, rs1=5 used -> forward_reg1_o=FWD_EX.
- Same with ex_rd_wr_en_i=0 -> FWD_MEM.
REQ-022 x0: rs1=0, EX rd=0, wr_en=1 -> FWD_RS, stall_o=0.
REQ-023 Load-use: EX load rd=7, rs2=7 used -> stall_o=1 for 1 cycle, stall_cnt_o=1. Next cycle: MEM rd=7 -> forward_reg2_o=FWD_MEM, stall_o=0.
REQ-024 Branch during load-use: branch_taken_i=1 with hazard present -> flush_o=1, stall_o=0, flush_cnt_o=1, then RUN.
REQ-025 Memory wait:
- mem_req_i=1, ack after 3 cycles -> freeze_o=1 for 3 cycles, then 0.
- ack withheld 255 cycles -> timeout_o=1 and held.
- rst_i=0 -> all outputs 0.
